// File: rtl/control_unit.sv
// RV32IM ID-stage decoder: opcode/funct3/funct7 -> ALU, memory, branch, immediate
// and writeback controls, registered into the ID/EX boundary (1-cycle latency).
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] alu_op,
    output logic       reg_write_en,
    output logic [2:0] mem_write,
    output logic [3:0] mem_read,
    output logic [3:0] branch_jump,
    output logic [3:0] imm_sel,
    output logic       data1_alu_sel,
    output logic       data2_alu_sel,
    output logic [1:0] wb_sel
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_FWD = 5'd18;

    localparam logic [3:0] IMM_NONE = 4'b0000;
    localparam logic [3:0] IMM_I    = 4'b0001;
    localparam logic [3:0] IMM_S    = 4'b0010;
    localparam logic [3:0] IMM_B    = 4'b0011;
    localparam logic [3:0] IMM_U    = 4'b0100;
    localparam logic [3:0] IMM_J    = 4'b0101;

    logic [4:0] alu_d;
    logic       rw_d;
    logic [2:0] mw_d;
    logic [3:0] mr_d;
    logic [3:0] bj_d;
    logic [3:0] imm_d;
    logic       d1_d;
    logic       d2_d;
    logic [1:0] wb_d;
    logic       legal;
    logic [4:0] base_alu;
    logic [4:0] mul_alu;

    // funct3 -> base-integer and M-extension operation tables
    always_comb begin
        base_alu = ALU_ADD;
        case (funct3)
            3'b000:  base_alu = 5'd0;
            3'b001:  base_alu = 5'd2;
            3'b010:  base_alu = 5'd3;
            3'b011:  base_alu = 5'd4;
            3'b100:  base_alu = 5'd5;
            3'b101:  base_alu = 5'd6;
            3'b110:  base_alu = 5'd8;
            default: base_alu = 5'd9;
        endcase
        mul_alu = 5'd10 + {2'b00, funct3};
    end

    always_comb begin
        alu_d = ALU_ADD;
        rw_d  = 1'b0;
        mw_d  = 3'b000;
        mr_d  = 4'b0000;
        bj_d  = 4'b0000;
        imm_d = IMM_NONE;
        d1_d  = 1'b0;
        d2_d  = 1'b0;
        wb_d  = 2'b00;
        legal = 1'b1;
        case (opcode)
            OP_R: begin
                rw_d = 1'b1;
                if (funct7 == F7_BASE)                      alu_d = base_alu;
                else if (funct7 == F7_MUL)                  alu_d = mul_alu;
                else if (funct7 == F7_ALT && funct3 == 3'b000) alu_d = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == 3'b101) alu_d = ALU_SRA;
                else                                        legal = 1'b0;
            end
            OP_I: begin
                rw_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_I;
                alu_d = base_alu;
                // Only the shift forms carry meaning in funct7
                if (funct3 == 3'b001 && funct7 != F7_BASE) legal = 1'b0;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       alu_d = ALU_SRA;
                    else if (funct7 != F7_BASE) legal = 1'b0;
                end
            end
            OP_LOAD: begin
                rw_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_I;
                wb_d  = 2'b01;
                mr_d  = {1'b1, funct3};
                legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            OP_STORE: begin
                d2_d  = 1'b1;
                imm_d = IMM_S;
                mw_d  = {1'b1, funct3[1:0]};
                legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            OP_BRANCH: begin
                d1_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_B;
                bj_d  = {1'b1, funct3};
                legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JAL: begin
                rw_d  = 1'b1;
                d1_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_J;
                wb_d  = 2'b10;
                bj_d  = 4'b1010;
            end
            OP_JALR: begin
                rw_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_I;
                wb_d  = 2'b10;
                bj_d  = 4'b1011;
                legal = (funct3 == 3'b000);
            end
            OP_LUI: begin
                rw_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_U;
                alu_d = ALU_FWD;
            end
            OP_AUIPC: begin
                rw_d  = 1'b1;
                d1_d  = 1'b1;
                d2_d  = 1'b1;
                imm_d = IMM_U;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal decodes register as the all-zero NOP bundle: no write side effects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_op        <= '0;
            reg_write_en  <= 1'b0;
            mem_write     <= '0;
            mem_read      <= '0;
            branch_jump   <= '0;
            imm_sel       <= '0;
            data1_alu_sel <= 1'b0;
            data2_alu_sel <= 1'b0;
            wb_sel        <= '0;
        end else if (legal) begin
            alu_op        <= alu_d;
            reg_write_en  <= rw_d;
            mem_write     <= mw_d;
            mem_read      <= mr_d;
            branch_jump   <= bj_d;
            imm_sel       <= imm_d;
            data1_alu_sel <= d1_d;
            data2_alu_sel <= d2_d;
            wb_sel        <= wb_d;
        end else begin
            alu_op        <= '0;
            reg_write_en  <= 1'b0;
            mem_write     <= '0;
            mem_read      <= '0;
            branch_jump   <= '0;
            imm_sel       <= '0;
            data1_alu_sel <= 1'b0;
            data2_alu_sel <= 1'b0;
            wb_sel        <= '0;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control bundles per instruction,
// compared one cycle after each instruction is presented.
module tb_control_unit;
    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] alu_op;
    logic       reg_write_en;
    logic [2:0] mem_write;
    logic [3:0] mem_read;
    logic [3:0] branch_jump;
    logic [3:0] imm_sel;
    logic       data1_alu_sel;
    logic       data2_alu_sel;
    logic [1:0] wb_sel;

    int checks = 0;
    int errors = 0;
    logic [24:0] exp_q[$];
    logic [24:0] got;
    logic [24:0] exp_v;

    control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_op(alu_op), .reg_write_en(reg_write_en), .mem_write(mem_write),
        .mem_read(mem_read), .branch_jump(branch_jump), .imm_sel(imm_sel),
        .data1_alu_sel(data1_alu_sel), .data2_alu_sel(data2_alu_sel), .wb_sel(wb_sel)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = {alu_op, reg_write_en, mem_write, mem_read, branch_jump,
                  imm_sel, data1_alu_sel, data2_alu_sel, wb_sel};

    // Expected bundle builder: alu, rw, mem_write, mem_read, branch_jump, imm, d1, d2, wb
    function automatic logic [24:0] mk(input logic [4:0] a, input logic rw,
                                       input logic [2:0] mw, input logic [3:0] mr,
                                       input logic [3:0] bj, input logic [3:0] im,
                                       input logic d1, input logic d2, input logic [1:0] wb);
        return {a, rw, mw, mr, bj, im, d1, d2, wb};
    endfunction

    // Driver: present an instruction away from the edge, then sample just after it
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        @(posedge clk);
        #1;
        checks++;
        if (got !== 25'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", got, 25'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_v = mk(5'd0, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_reset_midstream();
        drive(7'b0110011, 3'b000, 7'b0000000);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (got !== 25'h0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", got, 25'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got !== 25'h0) begin
            errors++;
            $display("FAIL reset_held_edge: got %h expected %h", got, 25'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_v = mk(5'd0, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_resume: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_alu_ops();
        logic [16:0] stim [7];
        stim = '{{7'b0110011, 3'b000, 7'b0000000},   // ADD
                 {7'b0110011, 3'b000, 7'b0100000},   // SUB
                 {7'b0110011, 3'b000, 7'b0000001},   // MUL
                 {7'b0110011, 3'b111, 7'b0000001},   // REMU
                 {7'b0010011, 3'b000, 7'b1111111},   // ADDI, funct7 ignored
                 {7'b0010011, 3'b101, 7'b0100000},   // SRAI
                 {7'b0010011, 3'b101, 7'b0000000}};  // SRLI
        exp_q.push_back(mk(5'd0,  1'b1, 3'b0, 4'b0, 4'b0, 4'b0000, 1'b0, 1'b0, 2'b00));
        exp_q.push_back(mk(5'd1,  1'b1, 3'b0, 4'b0, 4'b0, 4'b0000, 1'b0, 1'b0, 2'b00));
        exp_q.push_back(mk(5'd10, 1'b1, 3'b0, 4'b0, 4'b0, 4'b0000, 1'b0, 1'b0, 2'b00));
        exp_q.push_back(mk(5'd17, 1'b1, 3'b0, 4'b0, 4'b0, 4'b0000, 1'b0, 1'b0, 2'b00));
        exp_q.push_back(mk(5'd0,  1'b1, 3'b0, 4'b0, 4'b0, 4'b0001, 1'b0, 1'b1, 2'b00));
        exp_q.push_back(mk(5'd7,  1'b1, 3'b0, 4'b0, 4'b0, 4'b0001, 1'b0, 1'b1, 2'b00));
        exp_q.push_back(mk(5'd6,  1'b1, 3'b0, 4'b0, 4'b0, 4'b0001, 1'b0, 1'b1, 2'b00));
        for (int i = 0; i < 7; i++) begin
            drive(stim[i][16:10], stim[i][9:7], stim[i][6:0]);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL alu_ops[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_mem_ctrl_upper();
        logic [16:0] stim [7];
        stim = '{{7'b0000011, 3'b010, 7'b1010101},   // LW, funct7 ignored
                 {7'b0100011, 3'b010, 7'b0000000},   // SW
                 {7'b0100011, 3'b000, 7'b0000000},   // SB
                 {7'b1100011, 3'b000, 7'b0000000},   // BEQ
                 {7'b1101111, 3'b000, 7'b0000000},   // JAL
                 {7'b1100111, 3'b000, 7'b0000000},   // JALR
                 {7'b0110111, 3'b000, 7'b0000000}};  // LUI
        exp_q.push_back(mk(5'd0,  1'b1, 3'b000, 4'b1010, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'b01));
        exp_q.push_back(mk(5'd0,  1'b0, 3'b110, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'b00));
        exp_q.push_back(mk(5'd0,  1'b0, 3'b100, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'b00));
        exp_q.push_back(mk(5'd0,  1'b0, 3'b000, 4'b0000, 4'b1000, 4'b0011, 1'b1, 1'b1, 2'b00));
        exp_q.push_back(mk(5'd0,  1'b1, 3'b000, 4'b0000, 4'b1010, 4'b0101, 1'b1, 1'b1, 2'b10));
        exp_q.push_back(mk(5'd0,  1'b1, 3'b000, 4'b0000, 4'b1011, 4'b0001, 1'b0, 1'b1, 2'b10));
        exp_q.push_back(mk(5'd18, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'b00));
        for (int i = 0; i < 7; i++) begin
            drive(stim[i][16:10], stim[i][9:7], stim[i][6:0]);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL mem_ctrl[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    // Alternates legal and illegal decodes so a stale bundle cannot hide a NOP
    task automatic test_back_to_back();
        logic [16:0] stim [10];
        stim = '{{7'b0010111, 3'b000, 7'b0000000},   // AUIPC
                 {7'b0000000, 3'b000, 7'b0000000},   // unknown opcode
                 {7'b0110011, 3'b001, 7'b0000000},   // SLL
                 {7'b0110011, 3'b001, 7'b0100000},   // R alt funct7 illegal
                 {7'b1100011, 3'b111, 7'b0000000},   // BGEU
                 {7'b1100011, 3'b010, 7'b0000000},   // BRANCH illegal funct3
                 {7'b1100111, 3'b001, 7'b0000000},   // JALR illegal funct3
                 {7'b0010011, 3'b001, 7'b0100000},   // SLLI bad funct7
                 {7'b0000011, 3'b011, 7'b0000000},   // LOAD illegal funct3
                 {7'b0100011, 3'b011, 7'b0000000}};  // STORE illegal funct3
        exp_q.push_back(mk(5'd0, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'b00));
        exp_q.push_back(25'h0);
        exp_q.push_back(mk(5'd2, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'b00));
        exp_q.push_back(25'h0);
        exp_q.push_back(mk(5'd0, 1'b0, 3'b000, 4'b0000, 4'b1111, 4'b0011, 1'b1, 1'b1, 2'b00));
        exp_q.push_back(25'h0);
        exp_q.push_back(25'h0);
        exp_q.push_back(25'h0);
        exp_q.push_back(25'h0);
        exp_q.push_back(25'h0);
        for (int i = 0; i < 10; i++) begin
            drive(stim[i][16:10], stim[i][9:7], stim[i][6:0]);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_alu_ops();
        test_mem_ctrl_upper();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- RV32IM instruction decoder in the ID stage of the 5-stage pipeline.
- Decodes opcode/funct3/funct7 into the ALU, memory, branch, immediate and writeback control fields consumed downstream.
- Outputs are registered into the ID/EX boundary, giving 1-cycle latency.

Parameters:
- none

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; 0 clears all outputs
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12]
- funct7  input  7  instr[31:25]
- alu_op  output  5  ALU operation code
- reg_write_en  output  1  register file write enable
- mem_write  output  3  {en, size[1:0]}
- mem_read  output  4  {en, funct3[2:0]}
- branch_jump  output  4  {en, type[2:0]}
- imm_sel  output  4  immediate format select
- data1_alu_sel  output  1  0=rs1, 1=PC
- data2_alu_sel  output  1  0=rs2, 1=immediate
- wb_sel  output  2  00=ALU, 01=memory, 10=PC+4, 11 unused

Behaviour:
- Encodings:
  - Opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111.
  - alu_op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17, FWD=18 (pass operand 2).
  - imm_sel: 0000 none, 0001 I, 0010 S, 0011 B, 0100 U, 0101 J.
- Timing:
  - Decode is combinational; all outputs are registered on the rising clk edge.
  - Instruction presented before edge N appears on the outputs after edge N.
- Reset: reset low asynchronously forces every output to 0 (NOP bundle). The NOP bundle is held while reset is low; normal decode resumes at the first rising edge after release.
- R-type:
  - funct7=0000000 maps funct3 000..111 to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0100000 with funct3 000 gives SUB; with funct3 101 gives SRA.
  - funct7=0000001 maps funct3 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Fields: reg_write_en=1, data1=0, data2=0, imm_sel=0000, wb_sel=00.
- I-type ALU:
  - Same funct3 map as R with funct7=0000000. ADDI has no SUB form.
  - funct3 101: funct7=0100000 gives SRA, 0000000 gives SRL.
  - funct3 001 requires funct7=0000000.
  - Fields: reg_write_en=1, data2=1, imm_sel=I, wb_sel=00.
- LOAD:
  - alu_op=ADD, data2=1, imm_sel=I, reg_write_en=1, wb_sel=01, mem_read={1,funct3}.
  - Legal funct3: 000, 001, 010, 100, 101.
- STORE:
  - alu_op=ADD, data2=1, imm_sel=S, reg_write_en=0, mem_write={1,funct3[1:0]}.
  - Legal funct3: 000, 001, 010.
- BRANCH:
  - data1=1, data2=1, alu_op=ADD (target), imm_sel=B, reg_write_en=0, branch_jump={1,funct3}.
  - Legal funct3: 000, 001, 100, 101, 110, 111.
- JAL: data1=1, data2=1, ADD, imm_sel=J, reg_write_en=1, wb_sel=10, branch_jump=1010.
- JALR: requires funct3=000. data1=0, data2=1, ADD, imm_sel=I, reg_write_en=1, wb_sel=10, branch_jump=1011.
- LUI: data2=1, alu_op=FWD, imm_sel=U, reg_write_en=1, wb_sel=00.
- AUIPC: data1=1, data2=1, ADD, imm_sel=U, reg_write_en=1, wb_sel=00.
- Unlisted fields are 0 in every case.
- Illegal/unknown opcode, funct3 or funct7 combination → NOP bundle (all outputs 0). This guarantees no register or memory side effects.
- funct7 is ignored for every opcode except R-type and I-type shifts.

Test Plan:
- Reset low mid-stream with R ADD decoded → all outputs 0 immediately, with no clock edge needed. Release, then after the next edge the current instruction's decode appears.
- opcode=0110011, funct3=000:
  - funct7=0000000 → alu_op=0, reg_write_en=1, data2=0, wb_sel=00.
  - funct7=0100000 → alu_op=1.
  - funct7=0000001 → alu_op=10.
- opcode=0010011, funct3=000 → alu_op=0, data2=1, imm_sel=0001, reg_write_en=1. With funct3=101, funct7=0100000 → alu_op=7.
- Memory ops:
  - LW (0000011, funct3=010) → mem_read=1010, wb_sel=01, reg_write_en=1.
  - SW (0100011, funct3=010) → mem_write=110, imm_sel=0010, reg_write_en=0.
- Control flow:
  - BEQ (1100011, funct3=000) → branch_jump=1000, imm_sel=0011, data1=1, reg_write_en=0.
  - JAL → branch_jump=1010, wb_sel=10, imm_sel=0101.
- Upper-immediate ops:
  - LUI → alu_op=18, imm_sel=0100, data2=1.
  - AUIPC → alu_op=0, data1=1, data2=1.
- Illegal decodes → NOP bundle (all outputs 0), each after a single edge:
  - opcode=0000000.
  - R-type with funct7=0100000, funct3=001.
  - BRANCH funct3=010.
